vram_port_arbiter: RTL and testbench

VRAM_PORT_ARBITER -- requirements
Module: vram_port_arbiter

---
 rtl/vram_port_arbiter.sv | 127 ++++++++++++
 tb/tb_vram_port_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_port_arbiter.sv
// Three-requester arbiter in front of a single-port VRAM with 1-cycle synchronous read.
// Display has priority with starvation relief; cell engine and brush share round-robin.
module vram_port_arbiter #(
    parameter int ACTIVE_COLUMNS = 640,
    parameter int ACTIVE_ROWS    = 480,
    parameter int ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
    parameter int DATA_WIDTH     = 1,
    parameter int STARVE_LIMIT   = 16
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  disp_req_i,
    input  logic [ADDR_WIDTH-1:0] disp_addr_i,
    input  logic                  cell_req_i,
    input  logic                  cell_we_i,
    input  logic [ADDR_WIDTH-1:0] cell_addr_i,
    input  logic [DATA_WIDTH-1:0] cell_wr_data_i,
    input  logic                  brush_req_i,
    input  logic [ADDR_WIDTH-1:0] brush_addr_i,
    input  logic [DATA_WIDTH-1:0] brush_wr_data_i,
    output logic                  disp_gnt_o,
    output logic                  cell_gnt_o,
    output logic                  brush_gnt_o,
    output logic                  disp_rd_valid_o,
    output logic                  cell_rd_valid_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic [ADDR_WIDTH-1:0] vram_addr_o,
    output logic                  vram_wr_en_o,
    output logic [DATA_WIDTH-1:0] vram_wr_data_o,
    input  logic [DATA_WIDTH-1:0] vram_rd_data_i
);

    localparam int unsigned     CELLS      = ACTIVE_COLUMNS * ACTIVE_ROWS;
    localparam int              SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0]   STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {SEL_NONE, SEL_DISP, SEL_CELL, SEL_BRUSH} sel_e;

    sel_e                  sel;
    logic                  others_req;
    logic                  starved;
    logic                  in_range;
    logic                  wr_raw;

    logic                  rr_q, rr_d;
    logic [SW-1:0]         starve_q, starve_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  disp_pend_q, disp_pend_d;
    logic                  cell_pend_q, cell_pend_d;
    logic                  oor_q, oor_d;

    // NOTE: every signal gets a default at the top of the block so no path can infer a latch.
    always_comb begin
        sel            = SEL_NONE;
        others_req     = cell_req_i | brush_req_i;
        starved        = (starve_q == STARVE_MAX) && others_req;
        vram_addr_o    = addr_q;
        vram_wr_data_o = '0;
        wr_raw         = 1'b0;

        // Grants are masked while reset is held so the port is quiet during reset.
        if (!reset_ni)                                     sel = SEL_NONE;
        else if (disp_req_i && !starved)                   sel = SEL_DISP;
        else if (cell_req_i && (!brush_req_i || !rr_q))    sel = SEL_CELL;
        else if (brush_req_i)                              sel = SEL_BRUSH;

        case (sel)
            SEL_DISP: vram_addr_o = disp_addr_i;
            SEL_CELL: begin
                vram_addr_o    = cell_addr_i;
                vram_wr_data_o = cell_wr_data_i;
                wr_raw         = cell_we_i;
            end
            SEL_BRUSH: begin
                vram_addr_o    = brush_addr_i;
                vram_wr_data_o = brush_wr_data_i;
                wr_raw         = 1'b1;
            end
            default: ;
        endcase

        in_range     = 32'(vram_addr_o) < CELLS;
        vram_wr_en_o = wr_raw && in_range;
        disp_gnt_o   = (sel == SEL_DISP);
        cell_gnt_o   = (sel == SEL_CELL);
        brush_gnt_o  = (sel == SEL_BRUSH);

        rr_d = rr_q;
        if (cell_req_i && brush_req_i && (cell_gnt_o || brush_gnt_o))
            rr_d = cell_gnt_o;

        starve_d = starve_q;
        if (cell_gnt_o || brush_gnt_o || !others_req)
            starve_d = '0;
        else if (disp_gnt_o && (starve_q != STARVE_MAX))
            starve_d = starve_q + SW'(1);

        addr_d      = vram_addr_o;
        disp_pend_d = disp_gnt_o;
        cell_pend_d = cell_gnt_o && !cell_we_i;
        oor_d       = !in_range;
    end

    // NOTE: state flops use non-blocking assignments and clear asynchronously on reset.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rr_q        <= 1'b0;
            starve_q    <= '0;
            addr_q      <= '0;
            disp_pend_q <= 1'b0;
            cell_pend_q <= 1'b0;
            oor_q       <= 1'b0;
        end else begin
            rr_q        <= rr_d;
            starve_q    <= starve_d;
            addr_q      <= addr_d;
            disp_pend_q <= disp_pend_d;
            cell_pend_q <= cell_pend_d;
            oor_q       <= oor_d;
        end
    end

    assign disp_rd_valid_o = disp_pend_q;
    assign cell_rd_valid_o = cell_pend_q;
    assign rd_data_o       = ((disp_pend_q || cell_pend_q) && !oor_q) ? vram_rd_data_i : '0;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Self-checking bench for vram_port_arbiter: directed corner cases followed by a
// randomized run, all checked against a rule-level reference model.
module tb_vram_port_arbiter;

    localparam int          AW     = 19;
    localparam int unsigned CELLS  = 640 * 480;
    localparam int          STARVE = 16;

    logic          clk;
    logic          reset_ni;
    logic          disp_req_i, cell_req_i, cell_we_i, brush_req_i;
    logic [AW-1:0] disp_addr_i, cell_addr_i, brush_addr_i;
    logic          cell_wr_data_i, brush_wr_data_i;
    logic          disp_gnt_o, cell_gnt_o, brush_gnt_o;
    logic          disp_rd_valid_o, cell_rd_valid_o;
    logic          rd_data_o;
    logic [AW-1:0] vram_addr_o;
    logic          vram_wr_en_o, vram_wr_data_o;
    logic          vram_rd_data_i;

    vram_port_arbiter #(
        .ACTIVE_COLUMNS(640), .ACTIVE_ROWS(480), .ADDR_WIDTH(AW),
        .DATA_WIDTH(1), .STARVE_LIMIT(STARVE)
    ) dut (
        .clk_i(clk), .reset_ni(reset_ni),
        .disp_req_i(disp_req_i), .disp_addr_i(disp_addr_i),
        .cell_req_i(cell_req_i), .cell_we_i(cell_we_i), .cell_addr_i(cell_addr_i),
        .cell_wr_data_i(cell_wr_data_i),
        .brush_req_i(brush_req_i), .brush_addr_i(brush_addr_i),
        .brush_wr_data_i(brush_wr_data_i),
        .disp_gnt_o(disp_gnt_o), .cell_gnt_o(cell_gnt_o), .brush_gnt_o(brush_gnt_o),
        .disp_rd_valid_o(disp_rd_valid_o), .cell_rd_valid_o(cell_rd_valid_o),
        .rd_data_o(rd_data_o),
        .vram_addr_o(vram_addr_o), .vram_wr_en_o(vram_wr_en_o),
        .vram_wr_data_o(vram_wr_data_o), .vram_rd_data_i(vram_rd_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Environment VRAM; out-of-range reads return 1 so a missing mask is visible.
    bit env_mem [0:CELLS-1];
    always @(posedge clk) begin
        vram_rd_data_i <= (32'(vram_addr_o) < CELLS) ? env_mem[vram_addr_o] : 1'b1;
        if (vram_wr_en_o && (32'(vram_addr_o) < CELLS))
            env_mem[vram_addr_o] <= vram_wr_data_o;
    end

    // Staged stimulus, applied at the falling edge by tick().
    bit          s_rst_n;
    bit          s_dr, s_cr, s_cwe, s_br, s_cd, s_bd;
    logic [AW-1:0] s_da, s_ca, s_ba;

    // Reference model state.
    bit          ref_mem [0:CELLS-1];
    bit          m_fav_brush;
    int          m_starve;
    int unsigned m_last;
    bit          p_disp, p_cell, p_data;
    int          m_sel;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        int          sel;
        bit          others, exp_we, inr, d;
        int unsigned a;
        @(negedge clk);
        reset_ni        = s_rst_n;
        disp_req_i      = s_dr;  disp_addr_i  = s_da;
        cell_req_i      = s_cr;  cell_we_i    = s_cwe; cell_addr_i = s_ca; cell_wr_data_i = s_cd;
        brush_req_i     = s_br;  brush_addr_i = s_ba;  brush_wr_data_i = s_bd;
        #1;
        if (!s_rst_n) begin
            m_fav_brush = 0; m_starve = 0; m_last = 0;
            p_disp = 0; p_cell = 0; p_data = 0; m_sel = 0;
            check("rst_disp_gnt",  disp_gnt_o, 0);
            check("rst_cell_gnt",  cell_gnt_o, 0);
            check("rst_brush_gnt", brush_gnt_o, 0);
            check("rst_disp_vld",  disp_rd_valid_o, 0);
            check("rst_cell_vld",  cell_rd_valid_o, 0);
            check("rst_rd_data",   rd_data_o, 0);
            check("rst_wr_en",     vram_wr_en_o, 0);
            check("rst_addr",      vram_addr_o, 0);
            check("rst_wr_data",   vram_wr_data_o, 0);
        end else begin
            others = s_cr || s_br;
            sel = 0;
            if (s_dr && !(m_starve >= STARVE && others)) sel = 1;
            else if (s_cr && s_br) sel = m_fav_brush ? 3 : 2;
            else if (s_cr) sel = 2;
            else if (s_br) sel = 3;
            a = m_last; exp_we = 0; d = 0;
            case (sel)
                1: a = s_da;
                2: begin a = s_ca; exp_we = s_cwe; d = s_cd; end
                3: begin a = s_ba; exp_we = 1;     d = s_bd; end
                default: ;
            endcase
            inr    = a < CELLS;
            exp_we = exp_we && inr;

            check("disp_gnt",  disp_gnt_o,  sel == 1);
            check("cell_gnt",  cell_gnt_o,  sel == 2);
            check("brush_gnt", brush_gnt_o, sel == 3);
            check("disp_vld",  disp_rd_valid_o, p_disp);
            check("cell_vld",  cell_rd_valid_o, p_cell);
            check("rd_data",   rd_data_o, p_data);
            check("wr_en",     vram_wr_en_o, exp_we);
            check("addr",      vram_addr_o, a);
            if (exp_we) check("wr_data", vram_wr_data_o, d);

            if (s_cr && s_br && sel >= 2) m_fav_brush = (sel == 2);
            if (sel >= 2 || !others) m_starve = 0;
            else if (sel == 1 && m_starve < STARVE) m_starve++;
            p_disp = (sel == 1);
            p_cell = (sel == 2) && !s_cwe;
            p_data = (p_disp || p_cell) && inr ? ref_mem[a] : 1'b0;
            if (exp_we) ref_mem[a] = d;
            if (sel != 0) m_last = a;
            m_sel = sel;
        end
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(7, 0) == 0) return AW'($urandom_range(524287, CELLS));
        return AW'($urandom_range(63, 0));
    endfunction

    task automatic idle();
        s_dr = 0; s_cr = 0; s_br = 0; s_cwe = 0;
    endtask

    task automatic regen_disp();
        s_dr = ($urandom_range(9, 0) < 4); s_da = rand_addr();
    endtask
    task automatic regen_cell();
        s_cr = $urandom_range(1, 0); s_cwe = $urandom_range(1, 0);
        s_ca = rand_addr(); s_cd = $urandom_range(1, 0);
    endtask
    task automatic regen_brush();
        s_br = $urandom_range(1, 0); s_ba = rand_addr(); s_bd = $urandom_range(1, 0);
    endtask

    initial begin
        reset_ni = 0;
        disp_req_i = 0; cell_req_i = 0; cell_we_i = 0; brush_req_i = 0;
        disp_addr_i = '0; cell_addr_i = '0; brush_addr_i = '0;
        cell_wr_data_i = 0; brush_wr_data_i = 0;
        s_da = '0; s_ca = '0; s_ba = '0; s_cd = 0; s_bd = 0;
        for (int i = 0; i < 64; i++) begin
            ref_mem[i] = $urandom_range(1, 0);
            env_mem[i] = ref_mem[i];
        end
        ref_mem[5] = 1; env_mem[5] = 1;

        // Reset with every requester active: outputs must stay quiet.
        s_rst_n = 0;
        s_dr = 1; s_cr = 1; s_cwe = 1; s_br = 1; s_da = 3; s_ca = 4; s_ba = 9;
        tick(); tick();
        s_rst_n = 1; idle();
        tick();

        // Cell and brush contend: strict alternation starting with cell.
        s_cr = 1; s_cwe = 1; s_ca = 10; s_cd = 1; s_br = 1; s_ba = 20; s_bd = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rr_cell",  cell_gnt_o,  (i % 2) == 0);
            check("rr_brush", brush_gnt_o, (i % 2) == 1);
        end
        idle(); tick();

        // Display read of a cell holding 1.
        s_dr = 1; s_da = 5;
        tick();
        check("disp5_gnt", disp_gnt_o, 1);
        idle(); tick();
        check("disp5_vld",  disp_rd_valid_o, 1);
        check("disp5_data", rd_data_o, 1);

        // Starvation relief: 16 display grants, one cell grant, then display again.
        s_dr = 1; s_da = 7; s_cr = 1; s_cwe = 0; s_ca = 8;
        for (int i = 0; i < 18; i++) begin
            tick();
            check("starve_disp", disp_gnt_o, i != 16);
            check("starve_cell", cell_gnt_o, i == 16);
        end
        idle(); tick();

        // Out-of-range brush write is granted but suppressed.
        s_br = 1; s_ba = AW'(CELLS); s_bd = 1;
        tick();
        check("oor_brush_gnt", brush_gnt_o, 1);
        check("oor_brush_we",  vram_wr_en_o, 0);
        idle(); tick();

        // Out-of-range cell read returns 0 with valid.
        s_cr = 1; s_cwe = 0; s_ca = AW'(CELLS);
        tick();
        idle(); tick();
        check("oor_cell_vld",  cell_rd_valid_o, 1);
        check("oor_cell_data", rd_data_o, 0);

        // Reset right after a granted cell read cancels the pending valid.
        s_cr = 1; s_cwe = 0; s_ca = 5;
        tick();
        check("pre_rst_gnt", cell_gnt_o, 1);
        idle(); s_rst_n = 0;
        tick(); tick();
        s_rst_n = 1; s_cr = 1; s_cwe = 0; s_ca = 6;
        tick();
        check("post_rst_gnt", cell_gnt_o, 1);
        check("post_rst_vld", cell_rd_valid_o, 0);
        idle(); tick();

        // Randomized traffic; requests stay stable until granted.
        regen_disp(); regen_cell(); regen_brush();
        for (int i = 0; i < 800; i++) begin
            s_rst_n = ($urandom_range(59, 0) != 0);
            tick();
            if (!s_rst_n || m_sel == 1) regen_disp();
            if (!s_rst_n || m_sel == 2) regen_cell();
            if (!s_rst_n || m_sel == 3) regen_brush();
        end
        s_rst_n = 1; idle(); tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
